lsu_mem_bridge: RTL and testbench

- Memory-side responder for the core's data-access control signals: the main decoder raises memReq/memWrite; this block executes the access.
- Accepts one load/store per instruction and stalls the core until it completes.
- Drives a word-wide valid/ready data bus with byte strobes.
- Aligns store data, sign/zero-extends load data, and flags misaligned accesses.

---
 rtl/lsu_mem_bridge.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_bridge.sv
// Purpose: executes one core load/store per instruction on a word-wide valid/ready data bus
//          (store-lane alignment, load sign/zero extension, misaligned-access detection).
// Latency: minimum 3 cycles (IDLE accept, BUS, DONE); core stall cycles = 1 + BUS cycles.
// Backpressure: BUS holds address/data/strobes until i_busReady; the core is stalled meanwhile.
// Optional MEM_TIMEOUT_EN: abort a BUS wait after TIMEOUT_CYCLES cycles and flag o_busFault.
module lsu_mem_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_memReq,
  input  logic              i_memWrite,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_misaligned,
  output logic              o_busFault,
  output logic              o_busValid,
  output logic              o_busWrite,
  output logic [ADDR_W-1:0] o_busAddr,
  output logic [31:0]       o_busWdata,
  output logic [3:0]        o_busStrb,
  input  logic              i_busReady,
  input  logic [31:0]       i_busRdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              zext_q, zext_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        req_seen;
  logic        misal;
  logic        accept;
  logic        misal_evt;
  logic [3:0]  strb_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic        expire;

  // Request qualification: only IDLE listens to memReq; reset masks it so
  // the stall cannot survive an asynchronous reset.
  always_comb begin
    req_seen  = (state_q == S_IDLE) && i_memReq && !i_rst;
    misal     = (i_funct3[1:0] == 2'b11) ||
                ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    accept    = req_seen && !misal;
    misal_evt = req_seen && misal;
  end

  // Store lane alignment: strobes shifted by offset, data replicated across lanes
  always_comb begin
    case (i_funct3[1:0])
      2'b00: begin
        strb_new  = 4'b0001 << i_addr[1:0];
        wdata_new = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        strb_new  = 4'b0011 << i_addr[1:0];
        wdata_new = {2{i_wdata[15:0]}};
      end
      default: begin
        strb_new  = 4'b1111;
        wdata_new = i_wdata;
      end
    endcase
  end

  // Load extraction: pick the addressed lane(s) and extend to 32 bits
  always_comb begin
    case (off_q)
      2'd0:    lane_b = i_busRdata[7:0];
      2'd1:    lane_b = i_busRdata[15:8];
      2'd2:    lane_b = i_busRdata[23:16];
      default: lane_b = i_busRdata[31:24];
    endcase
    lane_h = off_q[1] ? i_busRdata[31:16] : i_busRdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{!zext_q && lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{!zext_q && lane_h[15]}}, lane_h};
      default: load_val = i_busRdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;

  // Wait counter: cleared on BUS entry, counts BUS cycles without ready
  always_comb begin
    expire  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q == S_BUS) && !i_busReady) begin
      if (expire) begin
        fault_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Timeout state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign o_busFault = fault_q;
`else
  assign expire     = 1'b0;
  assign o_busFault = 1'b0;
`endif

  // Main FSM next state and transaction capture
  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    zext_d  = zext_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d = i_memWrite;
          size_d  = i_funct3[1:0];
          zext_d  = i_funct3[2];
          off_d   = i_addr[1:0];
          addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
          wdata_d = wdata_new;
          strb_d  = strb_new;
          state_d = S_BUS;
        end else if (misal_evt) begin
          rdata_d = 32'd0;
        end
      end
      S_BUS: begin
        if (i_busReady) begin
          if (!write_q) rdata_d = load_val;
          state_d = S_DONE;
        end else if (expire) begin
          rdata_d = 32'd0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and captured-transaction registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      zext_q  <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      strb_q  <= 4'b0000;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      zext_q  <= zext_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs: bus side is registered, stall/misaligned react in the IDLE cycle
  always_comb begin
    o_busValid   = (state_q == S_BUS);
    o_busWrite   = (state_q == S_BUS) && write_q;
    o_busAddr    = addr_q;
    o_busWdata   = wdata_q;
    o_busStrb    = strb_q;
    o_stall      = accept || (state_q == S_BUS);
    o_misaligned = misal_evt;
    o_rdata      = misal_evt ? 32'd0 : rdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
module tb_lsu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq, memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, misaligned, busFault, busValid, busWrite, busReady;
  logic [31:0] rdata, busAddr, busWdata, busRdata;
  logic [3:0]  busStrb;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  lsu_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_memReq(memReq), .i_memWrite(memWrite),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_rdata(rdata), .o_misaligned(misaligned),
    .o_busFault(busFault), .o_busValid(busValid), .o_busWrite(busWrite),
    .o_busAddr(busAddr), .o_busWdata(busWdata), .o_busStrb(busStrb),
    .i_busReady(busReady), .i_busRdata(busRdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access rules computed arithmetically from the byte count
  function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
    int n;
    if (f3[1:0] == 2'b11) return 1'b1;
    n = 1 << f3[1:0];
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n;
    logic [31:0] r;
    n = 1 << f3[1:0];
    r = 32'd0;
    for (int i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % n))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int n;
    logic [63:0] mask, v;
    n = 1 << f3[1:0];
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = ({32'd0, rd} >> (8 * int'(a[1:0]))) & mask;
    if (n < 4 && !f3[2] && v[8 * n - 1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // One core access: IDLE request cycle, BUS wait cycles, DONE cycle
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits);
    bit mis, done;
    int n, stalls;
    @(negedge clk);
    memReq = 1'b1; memWrite = wr; funct3 = f3; addr = a; wdata = wd;
    busReady = 1'b0; busRdata = $urandom;
    #1;
    mis = m_misal(f3, a);
    stalls = 0;
    check("idle_stall", 32'(stall), 32'(!mis));
    check("idle_misal", 32'(misaligned), 32'(mis));
    check("idle_busvld", 32'(busValid), 32'd0);
    if (stall) stalls++;
    if (mis) begin
      exp_rdata = 32'd0;
      check("misal_rdata", rdata, exp_rdata);
      @(negedge clk);
      memReq = 1'b0;
      #1;
      check("misal_after_flag", 32'(misaligned), 32'd0);
      check("misal_after_vld", 32'(busValid), 32'd0);
      check("misal_after_rdata", rdata, exp_rdata);
      return;
    end
    n = 0; done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      // Core-side inputs wander during BUS; the captured request must hold.
      memWrite = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      busReady = (n == waits);
      busRdata = (busReady && !wr) ? rd : $urandom;
      #1;
      check("bus_vld", 32'(busValid), 32'd1);
      check("bus_stall", 32'(stall), 32'd1);
      check("bus_addr", busAddr, {a[31:2], 2'b00});
      check("bus_strb", 32'(busStrb), 32'(m_strb(f3, a)));
      check("bus_write", 32'(busWrite), 32'(wr));
      if (wr) check("bus_wdata", busWdata, m_wdata(f3, wd));
      if (stall) stalls++;
      if (busReady) done = 1'b1;
      n++;
    end
    check("bus_ready_bound", 32'(done), 32'd1);
    @(negedge clk);
    busReady = 1'b0; busRdata = $urandom;
    #1;
    if (!wr) exp_rdata = m_load(f3, a, rd);
    check("done_stall", 32'(stall), 32'd0);
    check("done_vld", 32'(busValid), 32'd0);
    check("done_fault", 32'(busFault), 32'd0);
    check("done_rdata", rdata, exp_rdata);
    check("stall_cycles", 32'(stalls), 32'(waits + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; memReq = 1'b0; memWrite = 1'b0; funct3 = 3'b000; addr = 32'd0;
    wdata = 32'd0; busReady = 1'b0; busRdata = 32'd0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_vld", 32'(busValid), 32'd0);
    check("rst_write", 32'(busWrite), 32'd0);
    check("rst_misal", 32'(misaligned), 32'd0);
    check("rst_fault", 32'(busFault), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", busAddr, 32'd0);
    check("rst_wdata", busWdata, 32'd0);
    check("rst_strb", 32'(busStrb), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed: LB with ready in the first BUS cycle
    access(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h8011_2233, 0);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    // Directed: LHU after 3 wait cycles
    access(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_0000, 3);
    check("lhu_rdata", rdata, 32'h0000_BEEF);
    // Directed: SB lane replication; o_rdata keeps the LHU result
    access(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 32'd0, 1);
    check("sb_keeps_rdata", rdata, 32'h0000_BEEF);
    // Directed: misaligned LW
    access(1'b0, 3'b010, 32'h0000_4002, 32'd0, 32'd0, 0);

    // Reset asserted in the middle of a BUS wait
    @(negedge clk);
    memReq = 1'b1; memWrite = 1'b0; funct3 = 3'b001; addr = 32'h0000_6002;
    @(negedge clk);
    #1;
    check("pre_rst_vld", 32'(busValid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_rdata = 32'd0;
    check("async_rst_vld", 32'(busValid), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_strb", 32'(busStrb), 32'd0);
    @(negedge clk);
    rst = 1'b0; memReq = 1'b0;
    access(1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'h1234_5678, 2);
    check("lw_after_rst", rdata, 32'h1234_5678);

`ifdef MEM_TIMEOUT_EN
    // Ready never arrives: abort after 4 BUS cycles with a one-cycle fault
    @(negedge clk);
    memReq = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h0000_7000; busReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("to_bus_vld", 32'(busValid), 32'd1);
    end
    @(negedge clk);
    #1;
    exp_rdata = 32'd0;
    check("to_done_vld", 32'(busValid), 32'd0);
    check("to_fault", 32'(busFault), 32'd1);
    check("to_rdata", rdata, 32'd0);
    check("to_stall", 32'(stall), 32'd0);
    @(negedge clk);
    memReq = 1'b0;
    #1;
    check("to_fault_clear", 32'(busFault), 32'd0);
`else
    // Without the timeout a long wait completes normally
    access(1'b0, 3'b100, 32'h0000_7001, 32'd0, 32'h0000_C300, 10);
    check("long_wait_rdata", rdata, 32'h0000_00C3);
`endif

    // Randomized back-to-back accesses against the reference model
    for (int k = 0; k < 60; k++) begin
      access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    @(negedge clk);
    memReq = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
